// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle MIPS-subset control FSM: states, opcodes,
// funct codes and datapath select values.
package mc_pkg;

    typedef enum logic [3:0] {
        StFetch  = 4'd0,
        StDecode = 4'd1,
        StMemAdr = 4'd2,
        StMemRd  = 4'd3,
        StMemWb  = 4'd4,
        StMemWr  = 4'd5,
        StExe    = 4'd6,
        StAluWb  = 4'd7,
        StBranch = 4'd8,
        StIExe   = 4'd9,
        StIWb    = 4'd10,
        StJump   = 4'd11,
        StJr     = 4'd12
    } state_e;

    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpBne   = 6'b000101;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpOri   = 6'b001101;
    localparam logic [5:0] OpLui   = 6'b001111;
    localparam logic [5:0] OpJ     = 6'b000010;
    localparam logic [5:0] OpJal   = 6'b000011;

    localparam logic [5:0] FnAdd = 6'b100000;
    localparam logic [5:0] FnSub = 6'b100010;
    localparam logic [5:0] FnAnd = 6'b100100;
    localparam logic [5:0] FnOr  = 6'b100101;
    localparam logic [5:0] FnSlt = 6'b101010;
    localparam logic [5:0] FnSll = 6'b000000;
    localparam logic [5:0] FnJr  = 6'b001000;

    localparam logic [3:0] AluAdd   = 4'b0000;
    localparam logic [3:0] AluSub   = 4'b0001;
    localparam logic [3:0] AluAnd   = 4'b0010;
    localparam logic [3:0] AluOr    = 4'b0011;
    localparam logic [3:0] AluSlt   = 4'b0100;
    localparam logic [3:0] AluSll   = 4'b0101;
    localparam logic [3:0] AluPassB = 4'b0110;

    localparam logic [1:0] ExtSign = 2'b00;
    localparam logic [1:0] ExtZero = 2'b01;
    localparam logic [1:0] ExtLui  = 2'b10;

    localparam logic [1:0] WdAluOut = 2'b00;
    localparam logic [1:0] WdMdr    = 2'b01;
    localparam logic [1:0] WdPc     = 2'b10;

    localparam logic [1:0] GprRd = 2'b00;
    localparam logic [1:0] GprRt = 2'b01;
    localparam logic [1:0] GprRa = 2'b10;

    localparam logic [1:0] NpcAlu    = 2'b00;
    localparam logic [1:0] NpcAluOut = 2'b01;
    localparam logic [1:0] NpcJump   = 2'b10;
    localparam logic [1:0] NpcReg    = 2'b11;

    localparam logic [1:0] SrcAPc    = 2'b00;
    localparam logic [1:0] SrcAReg   = 2'b01;
    localparam logic [1:0] SrcAShamt = 2'b10;

    localparam logic [1:0] SrcBReg   = 2'b00;
    localparam logic [1:0] SrcBFour  = 2'b01;
    localparam logic [1:0] SrcBImm   = 2'b10;
    localparam logic [1:0] SrcBBrOff = 2'b11;

    function automatic logic funct_legal(logic [5:0] funct);
        return funct inside {FnAdd, FnSub, FnAnd, FnOr, FnSlt, FnSll, FnJr};
    endfunction

endpackage

// File: rtl/mc_alu_dec.sv
// ALU operation and immediate-extension decode from op, funct and FSM state.
module mc_alu_dec
    import mc_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic [3:0] state,
    output logic [3:0] alu_op,
    output logic [1:0] ext_op,
    output logic       funct_ok
);

    always_comb begin
        alu_op   = AluAdd;
        ext_op   = ExtSign;
        funct_ok = funct_legal(funct);
        case (state)
            StExe: begin
                case (funct)
                    FnSub:   alu_op = AluSub;
                    FnAnd:   alu_op = AluAnd;
                    FnOr:    alu_op = AluOr;
                    FnSlt:   alu_op = AluSlt;
                    FnSll:   alu_op = AluSll;
                    default: alu_op = AluAdd;
                endcase
            end
            StBranch: alu_op = AluSub;
            StIExe: begin
                case (op)
                    OpOri: begin
                        alu_op = AluOr;
                        ext_op = ExtZero;
                    end
                    OpLui: begin
                        alu_op = AluPassB;
                        ext_op = ExtLui;
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multicycle MIPS-subset control FSM with mem_rdy stall handshake.
// Define MC_CTRL_PERF_EN to add cycle_cnt/instr_cnt performance counters.
module mc_ctrl
    import mc_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_rdy,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic       IorD,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [3:0] ALUOp,
    output logic [1:0] EXTOp,
    output logic [1:0] WDSel,
    output logic [1:0] GPRSel,
    output logic [1:0] NPCOp,
    output logic       illegal,
    output logic [3:0] state
`ifdef MC_CTRL_PERF_EN
    ,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instr_cnt
`endif
);

    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("CNT_W must be at least 1");
    end

    state_e     state_q, state_d;
    logic [3:0] alu_op;
    logic [1:0] ext_op;
    logic       funct_ok;

    mc_alu_dec u_alu_dec (
        .op       (op),
        .funct    (funct),
        .state    (state_q),
        .alu_op   (alu_op),
        .ext_op   (ext_op),
        .funct_ok (funct_ok)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= StFetch;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        PCWrite  = 1'b0;
        IRWrite  = 1'b0;
        MemWrite = 1'b0;
        RegWrite = 1'b0;
        IorD     = 1'b0;
        ALUSrcA  = SrcAPc;
        ALUSrcB  = SrcBReg;
        ALUOp    = alu_op;
        EXTOp    = ext_op;
        WDSel    = WdAluOut;
        GPRSel   = GprRd;
        NPCOp    = NpcAlu;
        illegal  = 1'b0;
        case (state_q)
            StFetch: begin
                ALUSrcB = SrcBFour;
                PCWrite = mem_rdy;
                IRWrite = mem_rdy;
                if (mem_rdy) state_d = StDecode;
            end
            StDecode: begin
                ALUSrcB = SrcBBrOff;
                case (op)
                    OpLw, OpSw:           state_d = StMemAdr;
                    OpBeq, OpBne:         state_d = StBranch;
                    OpAddi, OpOri, OpLui: state_d = StIExe;
                    OpJ, OpJal:           state_d = StJump;
                    OpRtype: begin
                        if (funct == FnJr) begin
                            state_d = StJr;
                        end else if (funct_ok) begin
                            state_d = StExe;
                        end else begin
                            illegal = 1'b1;
                            state_d = StFetch;
                        end
                    end
                    default: begin
                        illegal = 1'b1;
                        state_d = StFetch;
                    end
                endcase
            end
            StMemAdr: begin
                ALUSrcA = SrcAReg;
                ALUSrcB = SrcBImm;
                state_d = (op == OpSw) ? StMemWr : StMemRd;
            end
            StMemRd: begin
                IorD = 1'b1;
                if (mem_rdy) state_d = StMemWb;
            end
            StMemWb: begin
                RegWrite = 1'b1;
                GPRSel   = GprRt;
                WDSel    = WdMdr;
                state_d  = StFetch;
            end
            StMemWr: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
                if (mem_rdy) state_d = StFetch;
            end
            StExe: begin
                ALUSrcA = (funct == FnSll) ? SrcAShamt : SrcAReg;
                state_d = StAluWb;
            end
            StAluWb: begin
                RegWrite = 1'b1;
                state_d  = StFetch;
            end
            StBranch: begin
                ALUSrcA = SrcAReg;
                NPCOp   = NpcAluOut;
                PCWrite = (op == OpBeq) ? zero : ~zero;
                state_d = StFetch;
            end
            StIExe: begin
                ALUSrcA = SrcAReg;
                ALUSrcB = SrcBImm;
                state_d = StIWb;
            end
            StIWb: begin
                RegWrite = 1'b1;
                GPRSel   = GprRt;
                state_d  = StFetch;
            end
            StJump: begin
                PCWrite = 1'b1;
                NPCOp   = NpcJump;
                if (op == OpJal) begin
                    RegWrite = 1'b1;
                    GPRSel   = GprRa;
                    WDSel    = WdPc;
                end
                state_d = StFetch;
            end
            StJr: begin
                PCWrite = 1'b1;
                NPCOp   = NpcReg;
                state_d = StFetch;
            end
            default: state_d = StFetch;
        endcase
        state = state_q;
        // Reset silences every strobe immediately, including an in-flight store.
        if (rst) begin
            PCWrite  = 1'b0;
            IRWrite  = 1'b0;
            MemWrite = 1'b0;
            RegWrite = 1'b0;
            IorD     = 1'b0;
            ALUSrcA  = 2'b00;
            ALUSrcB  = 2'b00;
            ALUOp    = 4'b0000;
            EXTOp    = 2'b00;
            WDSel    = 2'b00;
            GPRSel   = 2'b00;
            NPCOp    = 2'b00;
            illegal  = 1'b0;
            state    = 4'd0;
        end
    end

`ifdef MC_CTRL_PERF_EN
    logic [CNT_W-1:0] cycle_cnt_q, instr_cnt_q;
    logic             instr_done;

    // Illegal instructions return from DECODE and are not counted.
    assign instr_done = (state_d == StFetch) && (state_q != StFetch) && (state_q != StDecode);

    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_cnt_q <= '0;
            instr_cnt_q <= '0;
        end else begin
            cycle_cnt_q <= cycle_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            if (instr_done) instr_cnt_q <= instr_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign cycle_cnt = cycle_cnt_q;
    assign instr_cnt = instr_cnt_q;
`endif

endmodule

// File: tb/tb_mc_ctrl.sv
// Randomized self-checking bench for mc_ctrl against a per-instruction phase model.
module tb_mc_ctrl;

    typedef struct packed {
        logic       pcw;
        logic       irw;
        logic       memw;
        logic       regw;
        logic       iord;
        logic [1:0] srca;
        logic [1:0] srcb;
        logic [3:0] aluop;
        logic [1:0] extop;
        logic [1:0] wdsel;
        logic [1:0] gprsel;
        logic [1:0] npcop;
        logic       ill;
        logic [3:0] st;
    } out_t;

    localparam int CIll = 0, CLw = 1, CSw = 2, CR = 3, CJr = 4, CBr = 5, CImm = 6, CJ = 7;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] op = '0, funct = '0;
    logic       zero = 1'b0, mem_rdy = 1'b0;
    logic       PCWrite, IRWrite, MemWrite, RegWrite, IorD, illegal;
    logic [1:0] ALUSrcA, ALUSrcB, EXTOp, WDSel, GPRSel, NPCOp;
    logic [3:0] ALUOp, state;
`ifdef MC_CTRL_PERF_EN
    logic [31:0] cycle_cnt, instr_cnt;
`endif

    mc_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .op       (op),
        .funct    (funct),
        .zero     (zero),
        .mem_rdy  (mem_rdy),
        .PCWrite  (PCWrite),
        .IRWrite  (IRWrite),
        .MemWrite (MemWrite),
        .RegWrite (RegWrite),
        .IorD     (IorD),
        .ALUSrcA  (ALUSrcA),
        .ALUSrcB  (ALUSrcB),
        .ALUOp    (ALUOp),
        .EXTOp    (EXTOp),
        .WDSel    (WDSel),
        .GPRSel   (GPRSel),
        .NPCOp    (NPCOp),
        .illegal  (illegal),
        .state    (state)
`ifdef MC_CTRL_PERF_EN
        ,
        .cycle_cnt(cycle_cnt),
        .instr_cnt(instr_cnt)
`endif
    );

    always #5 clk = ~clk;

    out_t act;
    assign act = {PCWrite, IRWrite, MemWrite, RegWrite, IorD, ALUSrcA, ALUSrcB, ALUOp, EXTOp,
                  WDSel, GPRSel, NPCOp, illegal, state};

    int n_checks = 0, n_errors = 0;
    logic [5:0] cur_op, cur_funct;
    int g_cyc, g_memw, g_pcw_br, g_ill;
    out_t g_jump;
    int g_states[$];
    int m_instr = 0;
    logic [31:0] m_cyc = '0;

    always @(posedge clk) begin
        if (rst) m_cyc <= '0;
        else     m_cyc <= m_cyc + 32'd1;
    end

    function automatic int cls(input logic [5:0] o, input logic [5:0] f);
        case (o)
            6'h23: return CLw;
            6'h2b: return CSw;
            6'h04, 6'h05: return CBr;
            6'h08, 6'h0d, 6'h0f: return CImm;
            6'h02, 6'h03: return CJ;
            6'h00: begin
                if (f == 6'h08) return CJr;
                if (f inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h00}) return CR;
                return CIll;
            end
            default: return CIll;
        endcase
    endfunction

    function automatic logic [3:0] r_alu(input logic [5:0] f);
        case (f)
            6'h22: return 4'd1;
            6'h24: return 4'd2;
            6'h25: return 4'd3;
            6'h2a: return 4'd4;
            6'h00: return 4'd5;
            default: return 4'd0;
        endcase
    endfunction

    // Expected outputs for one cycle spent in a given phase of an instruction.
    function automatic out_t exp_out(input int ph, input logic [5:0] o, input logic [5:0] f,
                                     input logic rdy, input logic z);
        out_t e;
        e = '0;
        e.st = 4'(ph);
        case (ph)
            0: begin e.srcb = 2'b01; e.pcw = rdy; e.irw = rdy; end
            1: begin e.srcb = 2'b11; e.ill = (cls(o, f) == CIll); end
            2: begin e.srca = 2'b01; e.srcb = 2'b10; end
            3: e.iord = 1'b1;
            4: begin e.regw = 1'b1; e.gprsel = 2'b01; e.wdsel = 2'b01; end
            5: begin e.iord = 1'b1; e.memw = 1'b1; end
            6: begin e.srca = (f == 6'h00) ? 2'b10 : 2'b01; e.aluop = r_alu(f); end
            7: e.regw = 1'b1;
            8: begin
                e.srca = 2'b01; e.aluop = 4'd1; e.npcop = 2'b01;
                e.pcw = (o == 6'h04) ? z : ~z;
            end
            9: begin
                e.srca = 2'b01; e.srcb = 2'b10;
                if (o == 6'h0d) begin e.extop = 2'b01; e.aluop = 4'd3; end
                if (o == 6'h0f) begin e.extop = 2'b10; e.aluop = 4'd6; end
            end
            10: begin e.regw = 1'b1; e.gprsel = 2'b01; end
            11: begin
                e.pcw = 1'b1; e.npcop = 2'b10;
                if (o == 6'h03) begin e.regw = 1'b1; e.gprsel = 2'b10; e.wdsel = 2'b10; end
            end
            12: begin e.pcw = 1'b1; e.npcop = 2'b11; end
            default: ;
        endcase
        return e;
    endfunction

    task automatic check_out(input string name, input out_t got, input out_t exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h required %h (op %h funct %h)", name, got, exp, cur_op,
                     cur_funct);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d required %0d", name, got, exp);
        end
    endtask

    task automatic step(input int ph, input logic rdy, input int zm);
        out_t e, got;
        logic z;
        z = (zm == 2) ? 1'($urandom_range(0, 1)) : zm[0];
        @(negedge clk);
        op = cur_op; funct = cur_funct; mem_rdy = rdy; zero = z;
        #1;
        got = act;
        e = exp_out(ph, cur_op, cur_funct, rdy, z);
        check_out("cycle", got, e);
        g_cyc++;
        if (got.memw) g_memw++;
        if (got.st == 4'd8 && got.pcw) g_pcw_br++;
        if (got.ill) g_ill++;
        if (got.st == 4'd11) g_jump = got;
        g_states.push_back(int'(got.st));
    endtask

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    // fs/ms: stall cycles before fetch/memory completes (-1 = random); zm: 0, 1, 2 = random.
    task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input int fs,
                             input int ms, input int zm);
        int c, n;
        c = cls(o, f);
        cur_op = o; cur_funct = f;
        g_cyc = 0; g_memw = 0; g_pcw_br = 0; g_ill = 0; g_jump = '0;
        g_states.delete();
        n = (fs < 0) ? int'($urandom_range(0, 2)) : fs;
        for (int i = 0; i < n; i++) step(0, 1'b0, zm);
        step(0, 1'b1, zm);
        step(1, rb(), zm);
        n = (ms < 0) ? int'($urandom_range(0, 2)) : ms;
        case (c)
            CLw: begin
                step(2, rb(), zm);
                for (int i = 0; i < n; i++) step(3, 1'b0, zm);
                step(3, 1'b1, zm);
                step(4, rb(), zm);
            end
            CSw: begin
                step(2, rb(), zm);
                for (int i = 0; i < n; i++) step(5, 1'b0, zm);
                step(5, 1'b1, zm);
            end
            CR:   begin step(6, rb(), zm); step(7, rb(), zm); end
            CJr:  step(12, rb(), zm);
            CBr:  step(8, rb(), zm);
            CImm: begin step(9, rb(), zm); step(10, rb(), zm); end
            CJ:   step(11, rb(), zm);
            default: ;
        endcase
        if (c != CIll) m_instr++;
    endtask

    task automatic check_perf(input string name, input int exp_instr);
`ifdef MC_CTRL_PERF_EN
        @(posedge clk);
        #1;
        check_int({name, "_cycles"}, int'(cycle_cnt), int'(m_cyc));
        check_int({name, "_instr"}, int'(instr_cnt), exp_instr);
`else
        if (name.len() < 0) $display("%0d", exp_instr);
`endif
    endtask

    initial begin
        int lw_seq[5];
        logic [5:0] ops[13];
        logic [5:0] fns[7];
        out_t zeros;
        zeros = '0;
        lw_seq = '{0, 1, 2, 3, 4};
        ops = '{6'h00, 6'h00, 6'h00, 6'h23, 6'h2b, 6'h04, 6'h05, 6'h08, 6'h0d, 6'h0f,
                6'h02, 6'h03, 6'h3f};
        fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h00, 6'h08};

        // Reset state: everything low.
        cur_op = 6'h23; cur_funct = '0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            mem_rdy = 1'b1;
            #1;
            check_out("reset", act, zeros);
        end
`ifdef MC_CTRL_PERF_EN
        check_int("reset_cycle_cnt", int'(cycle_cnt), 0);
        check_int("reset_instr_cnt", int'(instr_cnt), 0);
`endif
        rst = 1'b0;
        mem_rdy = 1'b0;

        run_instr(6'h23, 6'h00, 0, 0, 2);
        check_int("lw_cycles", g_cyc, 5);
        for (int i = 0; i < 5; i++)
            check_int("lw_state_seq", (i < g_states.size()) ? g_states[i] : -1, lw_seq[i]);
        run_instr(6'h00, 6'h20, 0, 0, 2);
        check_int("add_cycles", g_cyc, 4);
        run_instr(6'h02, 6'h00, 0, 0, 2);
        check_int("j_cycles", g_cyc, 3);
        check_perf("lw_add_j", 3);

        run_instr(6'h2b, 6'h00, 0, 2, 2);
        check_int("sw_stall_memwrite_cycles", g_memw, 3);
        check_int("sw_stall_cycles", g_cyc, 6);
        run_instr(6'h04, 6'h00, 0, 0, 1);
        check_int("beq_taken_pcwrite", g_pcw_br, 1);
        check_int("beq_cycles", g_cyc, 3);
        run_instr(6'h05, 6'h00, 0, 0, 1);
        check_int("bne_zero_pcwrite", g_pcw_br, 0);
        check_int("bne_cycles", g_cyc, 3);
        run_instr(6'h03, 6'h00, 0, 0, 2);
        check_int("jal_pcw_regw", int'(g_jump.pcw & g_jump.regw), 1);
        check_int("jal_gprsel", int'(g_jump.gprsel), 2);
        check_int("jal_wdsel", int'(g_jump.wdsel), 2);
        run_instr(6'h3f, 6'h00, 0, 0, 2);
        check_int("illegal_op_pulses", g_ill, 1);
        check_int("illegal_op_cycles", g_cyc, 2);
        run_instr(6'h00, 6'h3f, 1, 0, 2);
        check_int("illegal_funct_pulses", g_ill, 1);

        // Reset arriving mid-store abandons it.
        cur_op = 6'h2b; cur_funct = '0;
        step(0, 1'b1, 2);
        step(1, 1'b1, 2);
        step(2, 1'b1, 2);
        step(5, 1'b0, 2);
        @(negedge clk);
        rst = 1'b1; mem_rdy = 1'b0;
        m_instr = 0;
        #1;
        check_int("rst_memwrite", int'(MemWrite), 0);
        check_out("rst_in_memwr", act, zeros);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_int("after_rst_state", int'(state), 0);
        check_out("after_rst", act, exp_out(0, cur_op, cur_funct, 1'b0, zero));

        for (int k = 0; k < 300; k++) begin
            logic [5:0] o, f;
            int fi;
            o = ops[$urandom_range(0, 12)];
            fi = int'($urandom_range(0, 7));
            f = (fi == 7) ? 6'($urandom) : fns[fi];
            run_instr(o, f, -1, -1, 2);
        end
        check_perf("final", m_instr);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
Multicycle control FSM that sequences the shared datapath of the multicycle MIPS-subset CPU: one memory port for instruction fetch and data, one ALU, and the IR/MDR/A/B/ALUOut registers. It decodes op/funct from the IR and drives every write enable and mux select each cycle. A mem_rdy handshake allows memory accesses to stall. It instantiates inside mccpu next to the datapath; mem_rdy is tied to 1 for the single-cycle-latency dm.

Parameters:
CNT_W, 32, width of the performance counters (used only with MC_CTRL_PERF_EN).

Ports:
clk  in  1  CPU clock, rising edge
rst  in  1  reset; one clock domain, synchronous and active-high
op  in  6  IR[31:26]; stable from DECODE until the next FETCH
funct  in  6  IR[5:0]
zero  in  1  ALU zero flag, same cycle
mem_rdy  in  1  memory access completes this cycle
PCWrite  out  1  PC load enable (branch condition already folded in)
IRWrite  out  1  IR load enable
MemWrite  out  1  memory write strobe
RegWrite  out  1  register-file write enable
IorD  out  1  memory address select: 0 = PC, 1 = ALUOut
ALUSrcA  out  2  ALU A select: 00 = PC, 01 = A, 10 = shamt
ALUSrcB  out  2  ALU B select: 00 = B, 01 = 4, 10 = ext imm, 11 = sext imm << 2
ALUOp  out  4  ALU operation code
EXTOp  out  2  immediate extension: 00 = sign, 01 = zero, 10 = imm << 16
WDSel  out  2  register write data: 00 = ALUOut, 01 = MDR, 10 = PC
GPRSel  out  2  register write address: 00 = rd, 01 = rt, 10 = 31
NPCOp  out  2  next PC: 00 = ALU result, 01 = ALUOut, 10 = jump target, 11 = A (jr)
illegal  out  1  one-cycle pulse on an unsupported op or funct
state  out  4  current state, for debug

Behaviour:
- Supported instructions: R-type add, sub, and, or, slt, sll, jr; lw, sw, beq, bne, addi, ori, lui, j, jal.
- State register: 4 bits, updated on the clock edge.
- Outputs are decoded from the current state (Moore), except that PCWrite, IRWrite and MemWrite also depend on mem_rdy or zero as listed below.
- Default for every output not listed in a state: 0.
- While rst = 1: all outputs are 0, and state <= FETCH at the clock edge. Reset mid-instruction abandons that instruction; a pending MemWrite drops in the same cycle.
- ALUOp encoding: 0000 add, 0001 sub, 0010 and, 0011 or, 0100 slt, 0101 sll, 0110 passB.
- State encodings and per-state outputs:
  - FETCH (0): IorD = 0, ALUSrcA = 00, ALUSrcB = 01, ALUOp = add, NPCOp = 00. IRWrite = PCWrite = mem_rdy. Stays in FETCH until mem_rdy, then goes to DECODE.
  - DECODE (1): ALUSrcA = 00, ALUSrcB = 11, ALUOp = add (branch target into ALUOut). Next state:
    - lw or sw -> MEMADR
    - R-type -> EXE
    - R-type with jr -> JR
    - beq or bne -> BRANCH
    - addi, ori or lui -> IEXE
    - j or jal -> JUMP
    - anything else -> illegal = 1, then FETCH
  - MEMADR (2): ALUSrcA = 01, ALUSrcB = 10, EXTOp = 00, add. Goes to MEMRD for lw, MEMWR for sw.
  - MEMRD (3): IorD = 1. Holds until mem_rdy, then MEMWB.
  - MEMWB (4): RegWrite, GPRSel = 01, WDSel = 01. Then FETCH.
  - MEMWR (5): IorD = 1, MemWrite = 1 every cycle until mem_rdy, then FETCH.
  - EXE (6): ALUSrcA = 10 for sll, 01 otherwise; ALUSrcB = 00; ALUOp from funct. Then ALUWB.
  - ALUWB (7): RegWrite, GPRSel = 00, WDSel = 00. Then FETCH.
  - BRANCH (8): ALUSrcA = 01, ALUSrcB = 00, sub, NPCOp = 01. PCWrite = zero for beq, ~zero for bne. Then FETCH.
  - IEXE (9): ALUSrcA = 01, ALUSrcB = 10.
    - addi: EXTOp 00, add
    - ori: EXTOp 01, or
    - lui: EXTOp 10, passB
    - then IWB
  - IWB (10): RegWrite, GPRSel = 01, WDSel = 00. Then FETCH.
  - JUMP (11): PCWrite, NPCOp = 10. For jal also RegWrite, GPRSel = 10, WDSel = 10 (PC already holds PC + 4). Then FETCH.
  - JR (12): PCWrite, NPCOp = 11. Then FETCH.
- Codes 13-15 are unreachable; if entered, they go to FETCH with all outputs 0.
- Latency with mem_rdy = 1:
  - lw: 5 cycles
  - R-type, sw, addi, ori, lui: 4 cycles
  - beq, bne, j, jal, jr: 3 cycles
  - each mem_rdy = 0 cycle adds 1 cycle.

Optional Feature:
MC_CTRL_PERF_EN:
- Defined: adds outputs cycle_cnt[CNT_W-1:0] and instr_cnt[CNT_W-1:0].
  - Both clear on rst.
  - cycle_cnt increments every non-reset cycle.
  - instr_cnt increments on every transition into FETCH from a state other than FETCH or DECODE, so illegal instructions are not counted.
  - Both wrap modulo 2^CNT_W.
- Undefined: neither port nor counter exists.

Decomposition:
- Package mc_pkg holds:
  - state localparams
  - opcode and funct constants
  - ALUOp, EXTOp, WDSel, GPRSel, NPCOp, ALUSrcA and ALUSrcB encodings
- Sub-module mc_alu_dec: combinational (op, funct, state) -> ALUOp, EXTOp, plus a legal-funct flag.

Test Plan:
- Reset, then lw (op 100011) with mem_rdy = 1 -> state sequence 0, 1, 2, 3, 4, 0; RegWrite = 1 only in state 4, with GPRSel = 01 and WDSel = 01.
- sw with mem_rdy low for 2 cycles in MEMWR -> MemWrite = 1 for exactly 3 cycles, IorD = 1 throughout, then FETCH.
- beq with zero = 1 -> PCWrite = 1 in BRANCH with NPCOp = 01. bne with zero = 1 -> PCWrite = 0. Both take 3 cycles.
- jal (op 000011) -> JUMP asserts PCWrite, RegWrite, GPRSel = 10, WDSel = 10 together.
- op 111111 -> illegal = 1 for one cycle in DECODE, next state FETCH, no write enable asserted.
- rst asserted during MEMWR -> MemWrite = 0 in that cycle, state = 0 next cycle. With MC_CTRL_PERF_EN: cycle_cnt = 0, instr_cnt = 0 after reset; instr_cnt = 3 after lw, add, j.
